// File: rtl/next_pc_unit_if.sv
// Fetch-side bus of the next-PC unit: redirect requests coming from decode
// and the PC/flush/statistics values going back to fetch and decode.
interface next_pc_unit_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 Stall;
    logic                 Branch;
    logic                 Zero;
    logic [31:0]          SignImm;
    logic                 Jump;
    logic [27:0]          JumpTarget;
    logic                 JumpReg;
    logic [31:0]          RegTarget;
    logic [31:0]          PC;
    logic [31:0]          DecPCPlus4;
    logic                 Flush;
    logic [CNT_WIDTH-1:0] RedirectCount;

    // Decode/control side: issues requests, observes the fetch state.
    modport master (
        output Stall, Branch, Zero, SignImm, Jump, JumpTarget, JumpReg, RegTarget,
        input  PC, DecPCPlus4, Flush, RedirectCount
    );

    // The next-PC unit itself.
    modport slave (
        input  Stall, Branch, Zero, SignImm, Jump, JumpTarget, JumpReg, RegTarget,
        output PC, DecPCPlus4, Flush, RedirectCount
    );
endinterface

// File: rtl/next_pc_unit.sv
// Fetch-stage program-counter unit. Holds the fetch PC and the PC+4 of the
// instruction in decode, picks the next PC from sequential / branch / jump /
// jump-register sources, squashes the wrong-path instruction for one cycle
// after every taken redirect and counts taken redirects (saturating).
module next_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    next_pc_unit_if.slave   bus
);
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SRC_SEQ,
        SRC_BRANCH,
        SRC_JUMP,
        SRC_JREG
    } src_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state;
    logic [31:0]          pc_q;
    logic [31:0]          dec_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] target;
    src_t        src;
    logic        taken;

    // Candidate targets; all additions wrap modulo 2^32.
    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = dec_q + {bus.SignImm[29:0], 2'b00};
    assign jump_target   = {dec_q[31:28], bus.JumpTarget};

    // Priority select of the redirect source: jr, then j/jal, then taken beq.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        src    = SRC_SEQ;
        target = pc_plus4;
        if (bus.JumpReg) begin
            src    = SRC_JREG;
            target = bus.RegTarget;
        end else if (bus.Jump) begin
            src    = SRC_JUMP;
            target = jump_target;
        end else if (bus.Branch && bus.Zero) begin
            src    = SRC_BRANCH;
            target = branch_target;
        end
    end

    assign taken = (src != SRC_SEQ);

    // PC, decode PC+4, RUN/FLUSH state and redirect counter; reset wins over stall.
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            pc_q  <= RESET_PC;
            dec_q <= RESET_PC;
            state <= FLUSH;
            cnt_q <= '0;
        end else if (!bus.Stall) begin
            dec_q <= pc_plus4;
            case (state)
                RUN: begin
                    if (taken) begin
                        pc_q  <= target;
                        state <= FLUSH;
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end else begin
                        pc_q <= pc_plus4;
                    end
                end
                FLUSH: begin
                    // Requests seen here belong to the squashed instruction.
                    pc_q  <= pc_plus4;
                    state <= RUN;
                end
                default: begin
                    pc_q  <= pc_plus4;
                    state <= FLUSH;
                end
            endcase
        end
    end

    assign bus.PC            = pc_q;
    assign bus.DecPCPlus4    = dec_q;
    assign bus.Flush         = (state == FLUSH);
    assign bus.RedirectCount = cnt_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit. Each vector states the outputs expected in
// the current cycle and the inputs presented for the coming edge; the
// expectation is queued and a negedge monitor pops and compares it.
module tb_next_pc_unit;
    logic Clk;
    logic Reset;

    next_pc_unit_if #(.CNT_WIDTH(4)) bus ();

    next_pc_unit #(
        .RESET_PC (32'h0040_0000),
        .CNT_WIDTH(4)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] dec;
        logic        flush;
        logic [3:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Single comparison; reports on mismatch.
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: compare the DUT outputs of every cycle that has an expectation.
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, ".pc"},    bus.PC,                   e.pc);
            check({e.tag, ".dec"},   bus.DecPCPlus4,           e.dec);
            check({e.tag, ".flush"}, {31'd0, bus.Flush},       {31'd0, e.flush});
            check({e.tag, ".cnt"},   {28'd0, bus.RedirectCount}, {28'd0, e.cnt});
        end
    end

    // One cycle: queue the expected outputs for now, drive inputs for the next edge.
    task automatic vec(
        input string       tag,
        input logic        rst,
        input logic        stall,
        input logic        br,
        input logic        zr,
        input logic [31:0] si,
        input logic        jmp,
        input logic [27:0] jt,
        input logic        jr,
        input logic [31:0] rt,
        input logic [31:0] epc,
        input logic [31:0] edec,
        input logic        ef,
        input logic [3:0]  ecnt
    );
        exp_t e;
        Reset          = rst;
        bus.Stall      = stall;
        bus.Branch     = br;
        bus.Zero       = zr;
        bus.SignImm    = si;
        bus.Jump       = jmp;
        bus.JumpTarget = jt;
        bus.JumpReg    = jr;
        bus.RegTarget  = rt;
        e.tag   = tag;
        e.pc    = epc;
        e.dec   = edec;
        e.flush = ef;
        e.cnt   = ecnt;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    // Idle cycle: no requests, no stall, no reset.
    task automatic idle(input string tag, input logic [31:0] epc, input logic [31:0] edec,
                        input logic ef, input logic [3:0] ecnt);
        vec(tag, 0, 0, 0, 0, 32'd0, 0, 28'd0, 0, 32'd0, epc, edec, ef, ecnt);
    endtask

    initial begin
        logic [31:0] cur;
        logic [31:0] tgt;
        logic [3:0]  c_run;
        logic [3:0]  c_fl;
        int          guard;

        Reset          = 1'b1;
        bus.Stall      = 1'b0;
        bus.Branch     = 1'b0;
        bus.Zero       = 1'b0;
        bus.SignImm    = 32'd0;
        bus.Jump       = 1'b0;
        bus.JumpTarget = 28'd0;
        bus.JumpReg    = 1'b0;
        bus.RegTarget  = 32'd0;
        repeat (2) @(posedge Clk);
        #1;

        // Free run out of reset.
        idle("rst0", 32'h0040_0000, 32'h0040_0000, 1, 4'd0);
        idle("run1", 32'h0040_0004, 32'h0040_0004, 0, 4'd0);
        // Jump with DecPCPlus4 = 0x00400008.
        vec("jmp", 0, 0, 0, 0, 32'd0, 1, 28'h0100020, 0, 32'd0,
            32'h0040_0008, 32'h0040_0008, 0, 4'd0);
        idle("jmp_fl", 32'h0010_0020, 32'h0040_000C, 1, 4'd1);
        // Jump-register to set up DecPCPlus4 = 0x00400010.
        vec("jr_a", 0, 0, 0, 0, 32'd0, 0, 28'd0, 1, 32'h0040_000C,
            32'h0010_0024, 32'h0010_0024, 0, 4'd1);
        idle("jr_a_fl", 32'h0040_000C, 32'h0010_0028, 1, 4'd2);
        // Taken backward branch: 0x00400010 - 16.
        vec("beq_t", 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 28'd0, 0, 32'd0,
            32'h0040_0010, 32'h0040_0010, 0, 4'd2);
        idle("beq_t_fl", 32'h0040_0000, 32'h0040_0014, 1, 4'd3);
        idle("run2", 32'h0040_0004, 32'h0040_0004, 0, 4'd3);
        idle("run3", 32'h0040_0008, 32'h0040_0008, 0, 4'd3);
        idle("run4", 32'h0040_000C, 32'h0040_000C, 0, 4'd3);
        // Not-taken branch with DecPCPlus4 = 0x00400010.
        vec("beq_nt", 0, 0, 1, 0, 32'hFFFF_FFFC, 0, 28'd0, 0, 32'd0,
            32'h0040_0010, 32'h0040_0010, 0, 4'd3);
        // All sources at once: jr wins.
        vec("prio", 0, 0, 1, 1, 32'h0000_0004, 1, 28'h0ABCDE0, 1, 32'h0040_0100,
            32'h0040_0014, 32'h0040_0014, 0, 4'd3);
        // Stall through FLUSH; a jump shown during FLUSH must be dropped.
        vec("fl_st1", 0, 1, 0, 0, 32'd0, 0, 28'd0, 0, 32'd0,
            32'h0040_0100, 32'h0040_0018, 1, 4'd4);
        vec("fl_st2", 0, 1, 0, 0, 32'd0, 1, 28'h0000040, 0, 32'd0,
            32'h0040_0100, 32'h0040_0018, 1, 4'd4);
        vec("fl_st3", 0, 1, 0, 0, 32'd0, 1, 28'h0000040, 0, 32'd0,
            32'h0040_0100, 32'h0040_0018, 1, 4'd4);
        vec("fl_drop", 0, 0, 0, 0, 32'd0, 1, 28'h0000040, 0, 32'd0,
            32'h0040_0100, 32'h0040_0018, 1, 4'd4);
        // Stall in RUN holds the request; it is consumed once released.
        vec("run_st", 0, 1, 0, 0, 32'd0, 1, 28'h0000040, 0, 32'd0,
            32'h0040_0104, 32'h0040_0104, 0, 4'd4);
        vec("run_go", 0, 0, 0, 0, 32'd0, 1, 28'h0000040, 0, 32'd0,
            32'h0040_0104, 32'h0040_0104, 0, 4'd4);
        // Reset mid-FLUSH, with stall and a request also present.
        vec("fl_rst", 1, 1, 0, 0, 32'd0, 1, 28'h0000080, 0, 32'd0,
            32'h0000_0040, 32'h0040_0108, 1, 4'd5);
        idle("post_rst", 32'h0040_0000, 32'h0040_0000, 1, 4'd0);

        // 17 taken jumps, each followed by its FLUSH cycle: counter saturates at 15.
        cur = 32'h0040_0004;
        for (int i = 0; i < 17; i++) begin
            tgt   = 32'h0000_2000 + 32'(i) * 32'd64;
            c_run = (i > 15) ? 4'd15 : 4'(i);
            c_fl  = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            vec("sat_run", 0, 0, 0, 0, 32'd0, 1, tgt[27:0], 0, 32'd0, cur, cur, 0, c_run);
            idle("sat_fl", tgt, cur + 32'd4, 1, c_fl);
            cur = tgt + 32'd4;
        end

        // Sequential wrap past 0xFFFFFFFC.
        vec("jr_hi", 0, 0, 0, 0, 32'd0, 0, 28'd0, 1, 32'hFFFF_FFF8,
            32'h0000_2404, 32'h0000_2404, 0, 4'd15);
        idle("jr_hi_fl", 32'hFFFF_FFF8, 32'h0000_2408, 1, 4'd15);
        idle("pre_wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 4'd15);
        // Branch below zero wraps: 0x00000000 - 8.
        vec("beq_wrap", 0, 0, 1, 1, 32'hFFFF_FFFE, 0, 28'd0, 0, 32'd0,
            32'h0000_0000, 32'h0000_0000, 0, 4'd15);
        idle("beq_wrap_fl", 32'hFFFF_FFF8, 32'h0000_0004, 1, 4'd15);
        // Jump keeps DecPCPlus4[31:28].
        vec("jmp_hi", 0, 0, 0, 0, 32'd0, 1, 28'h0000100, 0, 32'd0,
            32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 4'd15);
        idle("jmp_hi_fl", 32'hF000_0100, 32'h0000_0000, 1, 4'd15);
        // Unaligned register target is loaded as-is.
        vec("jr_unal", 0, 0, 0, 0, 32'd0, 0, 28'd0, 1, 32'h0040_0103,
            32'hF000_0104, 32'hF000_0104, 0, 4'd15);
        idle("jr_unal_fl", 32'h0040_0103, 32'hF000_0108, 1, 4'd15);
        idle("final", 32'h0040_0107, 32'h0040_0107, 0, 4'd15);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge Clk);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
